// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
package toggle_hs_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer, synchronous active-high reset to 0.
// Only built with TOGGLE_HS_RX_SYNC_EN, the only configuration that uses it.
`ifdef TOGGLE_HS_RX_SYNC_EN
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/toggle_hs_rx.sv
// Toggle-handshake receiver: captures one word per req_tgl transition, returns ack_tgl.
// TOGGLE_HS_RX_SYNC_EN adds a 2-flop synchronizer on req_tgl for an asynchronous sender.
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              ack_tgl,
    output logic [CNT_W-1:0]  rx_count,
    output logic              err
);

    state_t             state, state_nxt;
    logic               req_s, req_d;
    logic               valid_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               ack_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;

`ifdef TOGGLE_HS_RX_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_s)
    );
`else
    assign req_s = req_tgl;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_d     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ack_tgl   <= 1'b0;
            rx_count  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_d     <= req_s;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            ack_tgl   <= ack_nxt;
            rx_count  <= cnt_nxt;
            err       <= err_nxt;
        end
    end

    // Next state: detect a pending request in IDLE, wait for acceptance in VALID.
    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        ack_nxt   = ack_tgl;
        cnt_nxt   = rx_count;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (req_s != ack_tgl) begin
                    data_nxt  = req_data;
                    valid_nxt = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                // The sender must not toggle again before seeing the ack.
                if (req_s != req_d) begin
                    err_nxt = 1'b1;
                end
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = ~ack_tgl;
                    cnt_nxt   = rx_count + CNT_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Self-checking bench for toggle_hs_rx (table-driven words plus corner-case sequences).
module tb_toggle_hs_rx;

`ifdef TOGGLE_HS_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            hold;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [15:0]   cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req_tgl;
    logic [DW-1:0] req_data;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          ack_tgl;
    logic [15:0]   rx_count;
    logic          err;

    int            tests;
    int            failed;
    logic [15:0]   exp_cnt;
    exp_t          sb[$];
    vec_t          vecs[6];

    toggle_hs_rx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack_tgl   (ack_tgl),
        .rx_count  (rx_count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int hold, input logic [DW-1:0] exp_d);
        exp_t e;
        int   n;
        logic a0, a1;
        @(posedge clk); #1;
        a0 = ack_tgl;
        a1 = ~a0;
        req_data  = d;
        req_tgl   = ~req_tgl;
        out_ready = (hold == 0);
        exp_cnt   = exp_cnt + 16'd1;
        sb.push_back('{data: exp_d, cnt: exp_cnt});
        wait_valid(n);
        check("latency", 32'(n), 32'(LAT));
        e = sb.pop_front();
        check("data", 32'(out_data), 32'(e.data));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(e.data));
            check("hold_ack", 32'(ack_tgl), 32'(a0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("pre_acc_valid", 32'(out_valid), 32'd1);
        check("pre_acc_ack", 32'(ack_tgl), 32'(a0));
        @(posedge clk); #1;
        check("acc_valid", 32'(out_valid), 32'd0);
        check("acc_ack", 32'(ack_tgl), 32'(a1));
        check("acc_cnt", 32'(rx_count), 32'(e.cnt));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_tgl   = 1'b0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        exp_cnt = 16'd0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack", 32'(ack_tgl), 32'd0);
        check("rst_cnt", 32'(rx_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
    endtask

    // Double toggle while a word is pending: sticky err, word and ack unaffected.
    task automatic err_seq();
        exp_t e;
        int   n;
        logic a0, a1;
        @(posedge clk); #1;
        a0 = ack_tgl;
        a1 = ~a0;
        req_data  = 8'h3E;
        req_tgl   = ~req_tgl;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        sb.push_back('{data: 8'h3E, cnt: exp_cnt});
        wait_valid(n);
        check("err_latency", 32'(n), 32'(LAT));
        e = sb.pop_front();
        check("err_data0", 32'(out_data), 32'(e.data));
        check("err_pre", 32'(err), 32'd0);
        req_data = 8'hC3;
        req_tgl  = ~req_tgl;
        repeat (2) @(posedge clk);
        #1;
        req_tgl = ~req_tgl;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("err_set", 32'(err), 32'd1);
        check("err_valid", 32'(out_valid), 32'd1);
        check("err_data", 32'(out_data), 32'(e.data));
        check("err_ack_held", 32'(ack_tgl), 32'(a0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("err_acc_valid", 32'(out_valid), 32'd0);
        check("err_acc_ack", 32'(ack_tgl), 32'(a1));
        check("err_acc_cnt", 32'(rx_count), 32'(e.cnt));
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("err_no_redetect", 32'(out_valid), 32'd0);
        check("err_one_ack", 32'(ack_tgl), 32'(a1));
        check("err_sticky", 32'(err), 32'd1);
    endtask

    // Reset while VALID drops the word; req_tgl=1 afterwards is a fresh request.
    task automatic rst_in_valid_seq();
        int n;
        do_reset();
        @(posedge clk); #1;
        req_data = 8'h77;
        req_tgl  = 1'b1;
        wait_valid(n);
        check("rv_latency", 32'(n), 32'(LAT));
        check("rv_data", 32'(out_data), 32'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rv_valid", 32'(out_valid), 32'd0);
        check("rv_ack", 32'(ack_tgl), 32'd0);
        check("rv_cnt", 32'(rx_count), 32'd0);
        check("rv_out_data", 32'(out_data), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = 16'd1;
        wait_valid(n);
        check("rv_new_latency", 32'(n), 32'(LAT));
        check("rv_new_data", 32'(out_data), 32'h77);
        @(posedge clk); #1;
        check("rv_new_valid", 32'(out_valid), 32'd0);
        check("rv_new_ack", 32'(ack_tgl), 32'd1);
        check("rv_new_cnt", 32'(rx_count), 32'(exp_cnt));
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        exp_cnt = 16'd0;

        vecs[0] = '{data: 8'hA5, hold: 0, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h3C, hold: 5, exp_data: 8'h3C};
        vecs[2] = '{data: 8'hFF, hold: 1, exp_data: 8'hFF};
        vecs[3] = '{data: 8'h00, hold: 0, exp_data: 8'h00};
        vecs[4] = '{data: 8'h5A, hold: 2, exp_data: 8'h5A};
        vecs[5] = '{data: 8'h81, hold: 0, exp_data: 8'h81};

        do_reset();

        foreach (vecs[i]) begin
            send_word(vecs[i].data, vecs[i].hold, vecs[i].exp_data);
        end

        // Preload the counter near its top so the wrap is reached quickly.
        @(posedge clk); #1;
        force dut.rx_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.rx_count;
        exp_cnt = 16'hFFFE;
        send_word(8'h11, 0, 8'h11);
        send_word(8'h22, 1, 8'h22);
        send_word(8'h33, 0, 8'h33);
        check("wrap_cnt", 32'(rx_count), 32'h0001);

        err_seq();
        rst_in_valid_seq();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
